// File: rtl/uart_pkg.sv
// Shared definitions for the BPSK UART link: FSM states, line levels, frame sizes and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic UART_START_LVL = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b0;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  // Odd parity: data ones plus this bit always total an odd count.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/uart_ser_fifo.sv
// Circular word FIFO for the UART serializer; used only when UART_SER_FIFO_EN is defined.
module uart_ser_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is left out of reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_serialize.sv
// UART transmit serializer: 11-bit frames (start, d0..d7, odd parity, stop) from a buffered word stream.
// Define UART_SER_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers one word.
module uart_serialize
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_baud,
  input  logic       rst_n,
  input  logic [7:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  output logic       uart_stream,
  output logic       busy,
  output logic       frame_done
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_serialize: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  uart_state_t               state;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      par;
  logic [2:0]                cnt;
  logic                      ready_en;

  logic                      push;
  logic                      pop;
  logic                      buf_empty;
  logic                      buf_full;
  logic [UART_DATA_BITS-1:0] buf_data;

  // ready_en keeps word_ready low for the first cycle after reset release.
  assign word_ready = ready_en && !buf_full;
  assign push       = word_valid && word_ready;
  assign pop        = ((state == IDLE) || (state == STOP)) && !buf_empty;
  assign busy       = (state != IDLE) || !buf_empty;

`ifdef UART_SER_FIFO_EN
  uart_ser_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk_baud),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (word_in),
    .pop       (pop),
    .pop_data  (buf_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;

  assign buf_empty = !hold_valid;
  assign buf_full  = hold_valid;
  assign buf_data  = hold_data;

  always_ff @(posedge clk_baud) begin
    if (!rst_n)    hold_valid <= 1'b0;
    else if (push) hold_valid <= 1'b1;
    else if (pop)  hold_valid <= 1'b0;
  end

  always_ff @(posedge clk_baud) begin
    if (push) hold_data <= word_in;
  end
`endif

  // Each state's line level is registered on the edge that enters it, so
  // uart_stream always shows the bit of the current state.
  // NOTE: all state here uses <= so every branch sees pre-edge values.
  always_ff @(posedge clk_baud) begin
    if (!rst_n) begin
      state       <= IDLE;
      uart_stream <= UART_IDLE_LVL;
      frame_done  <= 1'b0;
      ready_en    <= 1'b0;
      cnt         <= '0;
      shift       <= '0;
      par         <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      frame_done <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (pop) begin
            shift       <= buf_data;
            par         <= uart_parity(buf_data);
            state       <= START;
            uart_stream <= UART_START_LVL;
          end else begin
            state       <= IDLE;
            uart_stream <= UART_IDLE_LVL;
          end
        end
        START: begin
          state       <= DATA;
          cnt         <= '0;
          uart_stream <= shift[0];
        end
        DATA: begin
          if (cnt == 3'd7) begin
            state       <= PARITY;
            uart_stream <= par;
          end else begin
            cnt         <= cnt + 3'd1;
            uart_stream <= shift[cnt + 3'd1];
          end
        end
        PARITY: begin
          state       <= STOP;
          uart_stream <= UART_STOP_LVL;
          frame_done  <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          uart_stream <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serialize.sv
// Self-checking bench for uart_serialize: behavioural receiver and occupancy model, randomized words.
// Follows the DUT's build: define UART_SER_FIFO_EN for both to exercise the FIFO variant.
module tb_uart_serialize;

`ifdef UART_SER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk_baud = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] word_in = 8'h00;
  logic       word_valid = 1'b0;
  logic       word_ready;
  logic       uart_stream;
  logic       busy;
  logic       frame_done;

  uart_serialize #(.FIFO_DEPTH(4)) dut (
    .clk_baud    (clk_baud),
    .rst_n       (rst_n),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .uart_stream (uart_stream),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk_baud = ~clk_baud;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic       exp_line[$];
  logic       line_log[$];
  logic       fd_log[$];
  bit         gaps = 0;
  bit         armed = 0;
  int         accepts = 0;
  int         pops = 0;
  int         rx_idx = -1;
  logic [10:0] rx_bits;
  int         frames = 0;
  int         cyc = 0;
  int         base = 0;
  int         first_acc = -1;
  int         max_occ = 0;
  int         stall_cnt = 0;

  // Receiver: hunts for a 1 on the idle-0 line, collects 11 bits, checks against the scoreboard.
  task automatic monitor();
    int         occ;
    logic [7:0] data;
    logic [7:0] want;
    if (rx_idx < 0) begin
      if (uart_stream === 1'b1) begin
        rx_idx    = 0;
        rx_bits   = '0;
        rx_bits[0] = 1'b1;
        pops++;
      end else if (uart_stream !== 1'b0) begin
        checks++; errors++;
        $display("FAIL idle_line got=%b required=0", uart_stream);
      end
    end else begin
      rx_idx++;
      rx_bits[rx_idx] = uart_stream;
    end
    occ = accepts - pops;
    if (occ > max_occ) max_occ = occ;

    checks++;
    if (frame_done !== (rx_idx == 10)) begin
      errors++;
      $display("FAIL frame_done cyc=%0d got=%b required=%b", cyc, frame_done, (rx_idx == 10));
    end
    checks++;
    if (busy !== (rx_idx >= 0 || occ > 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, (rx_idx >= 0 || occ > 0));
    end
    checks++;
    if (word_ready !== (armed && occ < CAP)) begin
      errors++;
      $display("FAIL word_ready cyc=%0d got=%b required=%b", cyc, word_ready, (armed && occ < CAP));
    end

    if (rx_idx == 10) begin
      data = rx_bits[8:1];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame got=%02h required=none", data);
      end else begin
        want = exp_q.pop_front();
        if (data !== want) begin
          errors++;
          $display("FAIL frame_data got=%02h required=%02h", data, want);
        end
        checks++;
        if (rx_bits[9] !== (($countones(want) % 2) == 0)) begin
          errors++;
          $display("FAIL parity word=%02h got=%b required=%b", want, rx_bits[9],
                   (($countones(want) % 2) == 0));
        end
      end
      checks++;
      if (rx_bits[10] !== 1'b0) begin
        errors++;
        $display("FAIL stop_bit got=%b required=0", rx_bits[10]);
      end
      frames++;
      rx_idx = -1;
    end
  endtask

  // One clock: drive the handshake, step past the edge, then check outputs.
  task automatic tick();
    bit accepted;
    bit in_reset;
    if (!word_valid && tx_q.size() > 0 && rst_n && (!gaps || $urandom_range(0, 2) == 0)) begin
      word_valid = 1'b1;
      word_in    = tx_q[0];
    end
    accepted = rst_n && word_valid && (word_ready === 1'b1);
    if (rst_n && word_valid && word_ready === 1'b0) stall_cnt++;
    in_reset = !rst_n;
    @(posedge clk_baud);
    #1;
    cyc++;
    if (accepted) begin
      exp_q.push_back(tx_q.pop_front());
      accepts++;
      if (first_acc < 0) first_acc = cyc;
      word_valid = 1'b0;
      word_in    = 8'($urandom);
    end
    line_log.push_back(uart_stream);
    fd_log.push_back(frame_done);
    if (in_reset) begin
      checks++;
      if ({uart_stream, busy, frame_done, word_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs line=%b busy=%b done=%b ready=%b required 0 0 0 0",
                 uart_stream, busy, frame_done, word_ready);
      end
      armed  = 0;
      accepts = 0;
      pops   = 0;
      rx_idx = -1;
      exp_q.delete();
      tx_q.delete();
      word_valid = 1'b0;
    end else begin
      armed = 1;
      monitor();
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0 || rx_idx >= 0 || word_valid) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout cycles=%0d required_below=%0d", name, n, budget);
    end
    repeat (3) tick();
  endtask

  task automatic start_capture();
    line_log.delete();
    fd_log.delete();
    exp_line.delete();
    base      = cyc;
    first_acc = -1;
  endtask

  task automatic add_frame(input logic [7:0] w);
    exp_line.push_back(1'b1);
    for (int i = 0; i < 8; i++) exp_line.push_back(w[i]);
    exp_line.push_back(($countones(w) % 2) == 0);
    exp_line.push_back(1'b0);
  endtask

  // Compares the line from one edge after the first accept against exp_line.
  task automatic check_line(input string name);
    int idx;
    for (int j = 0; j <= exp_line.size(); j++) begin
      idx = first_acc + j - base - 1;
      checks++;
      if (first_acc < 0 || idx < 0 || idx >= line_log.size()) begin
        errors++;
        $display("FAIL %s bit %0d got=missing required=present", name, j);
      end else if (j == 0) begin
        if (line_log[idx] !== 1'b0) begin
          errors++;
          $display("FAIL %s accept_edge_line got=%b required=0", name, line_log[idx]);
        end
      end else if (line_log[idx] !== exp_line[j-1] || fd_log[idx] !== ((j % 11) == 0)) begin
        errors++;
        $display("FAIL %s bit %0d line got=%b required=%b done got=%b required=%b",
                 name, j, line_log[idx], exp_line[j-1], fd_log[idx], ((j % 11) == 0));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_single_a5();
    logic a5_bits[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    start_capture();
    for (int i = 0; i < 11; i++) exp_line.push_back(a5_bits[i]);
    gaps = 0;
    tx_q.push_back(8'hA5);
    drain("a5", 60);
    check_line("a5_frame");
  endtask

  task automatic test_back_to_back();
    start_capture();
    add_frame(8'h00);
    add_frame(8'hFF);
    gaps = 0;
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hFF);
    drain("b2b", 80);
    check_line("b2b_frames");
  endtask

  task automatic test_random_loopback();
    int f0 = frames;
    gaps = 1;
    for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
    drain("loopback", 12000);
    checks++;
    if (frames - f0 != 256) begin
      errors++;
      $display("FAIL loopback_count got=%0d required=256", frames - f0);
    end
  endtask

  task automatic test_fill();
    int f0 = frames;
    gaps      = 0;
    stall_cnt = 0;
    max_occ   = 0;
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
    drain("fill", 200);
    checks++;
    if (stall_cnt == 0) begin
      errors++;
      $display("FAIL fill_stall got=0 required=nonzero");
    end
    checks++;
    if (max_occ != CAP) begin
      errors++;
      $display("FAIL fill_occupancy got=%0d required=%0d", max_occ, CAP);
    end
    checks++;
    if (frames - f0 != 6) begin
      errors++;
      $display("FAIL fill_count got=%0d required=6", frames - f0);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    int n = 0;
    gaps = 0;
    tx_q.push_back(8'h3C);
    while (rx_idx != 4 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (rx_idx != 4) begin
      errors++;
      $display("FAIL midframe_reach_d3 got=%0d required=4", rx_idx);
    end
    f0 = frames;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (frames != f0) begin
      errors++;
      $display("FAIL midframe_aborted frames got=%0d required=%0d", frames, f0);
    end
    start_capture();
    add_frame(8'h81);
    tx_q.push_back(8'h81);
    drain("after_reset", 60);
    check_line("post_reset_81");
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_random_loopback();
    test_fill();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
